fll_cfg_sequencer: RTL

FLL_CFG_SEQUENCER -- requirements
Module: fll_cfg_sequencer

---
 rtl/fll_cfg_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fll_cfg_sequencer.sv
// FLL configuration sequencer: writes the two boot config registers, waits for a
// stable lock (bounded by a timeout), then gates core fetch and forwards software accesses.
module fll_cfg_sequencer #(
    parameter logic [31:0] BOOT_CFG1    = 32'hC000_05F5,
    parameter logic [31:0] BOOT_CFG2    = 32'h0000_4100,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_wdata_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_rdata_i,
    input  logic        fll_lock_i,
    input  logic        sw_req_i,
    input  logic        sw_wrn_i,
    input  logic [1:0]  sw_add_i,
    input  logic [31:0] sw_wdata_i,
    output logic        sw_ack_o,
    output logic [31:0] sw_rdata_o,
    input  logic        fetch_enable_i,
    output logic        fetch_enable_o,
    output logic        boot_done_o,
    output logic        lock_timeout_o
);

    typedef enum logic [3:0] {
        RST, CFG1, GAP1, CFG2, GAP2, LOCK, IDLE, SW, SWGAP
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        sw_wrn_q;
    logic [1:0]  sw_add_q;
    logic [31:0] sw_wdata_q;
    logic [31:0] sw_rdata_q;
    logic        boot_done_q;
    logic        lock_timeout_q;
    logic [15:0] to_cnt;
    logic [1:0]  stab_cnt;

    logic        lock_ok;
    logic        to_hit;

    // Lock needs four consecutive high samples: three counted plus the current one.
    assign lock_ok = fll_lock_i && (stab_cnt == 2'd3);
    assign to_hit  = (to_cnt == LOCK_TIMEOUT - 16'd1);

    always_comb begin
        next_state  = state;
        fll_req_o   = 1'b0;
        fll_wrn_o   = 1'b0;
        fll_add_o   = '0;
        fll_wdata_o = '0;
        case (state)
            RST:  next_state = CFG1;
            CFG1: begin
                fll_req_o   = 1'b1;
                fll_add_o   = 2'd1;
                fll_wdata_o = BOOT_CFG1;
                if (fll_ack_i) next_state = GAP1;
            end
            GAP1: next_state = CFG2;
            CFG2: begin
                fll_req_o   = 1'b1;
                fll_add_o   = 2'd2;
                fll_wdata_o = BOOT_CFG2;
                if (fll_ack_i) next_state = GAP2;
            end
            GAP2: next_state = LOCK;
            LOCK: begin
                if (lock_ok || to_hit) next_state = IDLE;
            end
            IDLE: begin
                if (sw_req_i) next_state = SW;
            end
            SW: begin
                fll_req_o   = 1'b1;
                fll_wrn_o   = sw_wrn_q;
                fll_add_o   = sw_add_q;
                fll_wdata_o = sw_wdata_q;
                if (fll_ack_i) next_state = SWGAP;
            end
            SWGAP: next_state = IDLE;
            default: next_state = RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= RST;
            sw_wrn_q       <= 1'b0;
            sw_add_q       <= '0;
            sw_wdata_q     <= '0;
            sw_rdata_q     <= '0;
            boot_done_q    <= 1'b0;
            lock_timeout_q <= 1'b0;
            to_cnt         <= '0;
            stab_cnt       <= '0;
        end else begin
            state <= next_state;

            // Counters run only inside LOCK so they always start from zero on entry.
            if (state == LOCK) begin
                to_cnt   <= to_cnt + 16'd1;
                stab_cnt <= fll_lock_i ? stab_cnt + 2'd1 : 2'd0;
            end else begin
                to_cnt   <= '0;
                stab_cnt <= '0;
            end

            if (state == LOCK && next_state == IDLE) begin
                boot_done_q <= 1'b1;
                if (!lock_ok) lock_timeout_q <= 1'b1;
            end

            if (state == IDLE && sw_req_i) begin
                sw_wrn_q   <= sw_wrn_i;
                sw_add_q   <= sw_add_i;
                sw_wdata_q <= sw_wdata_i;
            end

            if (state == SW && fll_ack_i) sw_rdata_q <= fll_rdata_i;
        end
    end

    assign sw_ack_o       = (state == SWGAP);
    assign sw_rdata_o     = sw_rdata_q;
    assign boot_done_o    = boot_done_q;
    assign lock_timeout_o = lock_timeout_q;
    assign fetch_enable_o = fetch_enable_i & boot_done_q;

endmodule
